// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Shared ALU control word consumed by the ALU stage and produced by the decode stage.
//   pre_x_en/pre_x_sub, pre_y_en/pre_y_sub : pre-adder enable / subtract per lane
//   mul_x_en/mul_x_sel, mul_y_en/mul_y_sel : multiplier enable / operand select per lane
//   post_en/post_sub                       : post-adder enable / subtract
package alu_pkg;

  typedef struct packed {
    logic       pre_x_en;
    logic       pre_x_sub;
    logic       pre_y_en;
    logic       pre_y_sub;
    logic       mul_x_en;
    logic [2:0] mul_x_sel;
    logic       mul_y_en;
    logic [2:0] mul_y_sel;
    logic       post_en;
    logic       post_sub;
  } alu_ctrl_t;

endpackage

// File: rtl/decode_stage_skid.sv
// Module: decode_stage_skid
// Decode stage between RX and the ALU. Decodes the opcode into an ALU control word,
// routes operands onto the X/Y lanes (optional x1<->y1 swap) and hands the result to
// the ALU through a 2-entry skid buffer, so the stage sustains one command per cycle
// while rx_ready_out stays a pure register output.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_valid_in/rx_ready_out RX handshake (ready is registered)
//   op [OPW-1:0]             opcode in [3:0]; op[4] = lane swap when OPW>4
//   a1,a2,b1,b2              operands from RX
//   cmd_valid_out/cmd_ready_in  ALU handshake
//   ctrl, x0,x1,y0,y1        command to the ALU, driven from the main entry only
//   issue_cnt [CNT_W-1:0]    commands handed to the ALU, wraps
module decode_stage_skid #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned OPW       = 4,
  parameter int unsigned DROP_NOOP = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid_in,
  output logic               rx_ready_out,
  input  logic [OPW-1:0]     op,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   a2,
  input  logic [WIDTH-1:0]   b1,
  input  logic [WIDTH-1:0]   b2,
  output logic               cmd_valid_out,
  input  logic               cmd_ready_in,
  output alu_pkg::alu_ctrl_t ctrl,
  output logic [WIDTH-1:0]   x0,
  output logic [WIDTH-1:0]   x1,
  output logic [WIDTH-1:0]   y0,
  output logic [WIDTH-1:0]   y1,
  output logic [CNT_W-1:0]   issue_cnt
);

  import alu_pkg::*;

  typedef enum logic [3:0] {
    OP_NOOP   = 4'h0,
    OP_DOT2   = 4'h1,
    OP_WSUM   = 4'h2,
    OP_PROJU  = 4'h3,
    OP_SUMSQ  = 4'h4,
    OP_SCSUM  = 4'h5,
    OP_VADD2  = 4'h6,
    OP_VSUB2  = 4'h7,
    OP_DIFF2  = 4'h8,
    OP_DET2   = 4'h9,
    OP_DIFFSQ = 4'hA,
    OP_DIST2  = 4'hB,
    OP_POLY   = 4'hC,
    OP_SCMUL  = 4'hD,
    OP_LERPX  = 4'hE,
    OP_LERPY  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    alu_ctrl_t        ctrl;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
  } entry_t;

  state_t    state_q, state_n;
  entry_t    main_q, skid_q;
  entry_t    dec_entry;
  alu_ctrl_t dec_ctrl;
  opcode_t   opcode;
  logic      rx_ready_q;
  logic      swap;
  logic      drop_noop;
  logic      accept, load, issue;
  logic      main_ld_new, main_ld_skid, skid_ld;
  logic      op_unused;

  // Upper opcode bits beyond the swap flag carry no meaning here.
  assign op_unused = ^op;

  generate
    if (OPW > 4) begin : g_swap
      assign swap = op[4];
    end else begin : g_noswap
      assign swap = 1'b0;
    end
  endgenerate

  assign opcode = opcode_t'(op[3:0]);

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_ctrl           = '0;
    dec_ctrl.mul_x_sel = 3'd1;
    dec_ctrl.mul_y_sel = 3'd1;
    case (opcode)
      OP_DOT2, OP_WSUM, OP_PROJU, OP_SUMSQ, OP_SCSUM: begin
        dec_ctrl.mul_x_en = 1'b1;
        dec_ctrl.mul_y_en = 1'b1;
        dec_ctrl.post_en  = 1'b1;
      end
      OP_VADD2, OP_VSUB2: begin
        dec_ctrl.pre_x_en  = 1'b1;
        dec_ctrl.pre_y_en  = 1'b1;
        dec_ctrl.pre_x_sub = (opcode == OP_VSUB2);
        dec_ctrl.pre_y_sub = (opcode == OP_VSUB2);
        dec_ctrl.mul_x_en  = 1'b1;
        dec_ctrl.mul_y_en  = 1'b1;
        dec_ctrl.mul_x_sel = 3'd4;
        dec_ctrl.mul_y_sel = 3'd4;
      end
      OP_DIFF2, OP_DET2, OP_DIFFSQ: begin
        dec_ctrl.mul_x_en = 1'b1;
        dec_ctrl.mul_y_en = 1'b1;
        dec_ctrl.post_en  = 1'b1;
        dec_ctrl.post_sub = 1'b1;
      end
      OP_DIST2: begin
        dec_ctrl.pre_x_en  = 1'b1;
        dec_ctrl.pre_y_en  = 1'b1;
        dec_ctrl.pre_x_sub = 1'b1;
        dec_ctrl.pre_y_sub = 1'b1;
        dec_ctrl.mul_x_en  = 1'b1;
        dec_ctrl.mul_y_en  = 1'b1;
        dec_ctrl.mul_x_sel = 3'd2;
        dec_ctrl.mul_y_sel = 3'd2;
        dec_ctrl.post_en   = 1'b1;
        dec_ctrl.post_sub  = 1'b1;
      end
      OP_POLY: begin
        dec_ctrl.pre_x_en = 1'b1;
        dec_ctrl.post_en  = 1'b1;
      end
      OP_SCMUL: begin
        dec_ctrl.mul_x_en = 1'b1;
        dec_ctrl.mul_y_en = 1'b1;
      end
      OP_LERPX: begin
        dec_ctrl.mul_x_en  = 1'b1;
        dec_ctrl.mul_x_sel = 3'd4;
        dec_ctrl.pre_y_en  = 1'b1;
        dec_ctrl.pre_y_sub = 1'b1;
        dec_ctrl.mul_y_en  = 1'b1;
        dec_ctrl.mul_y_sel = 3'd3;
        dec_ctrl.post_en   = 1'b1;
      end
      OP_LERPY: begin
        dec_ctrl.pre_x_en  = 1'b1;
        dec_ctrl.pre_x_sub = 1'b1;
        dec_ctrl.mul_x_en  = 1'b1;
        dec_ctrl.mul_x_sel = 3'd3;
        dec_ctrl.mul_y_en  = 1'b1;
        dec_ctrl.mul_y_sel = 3'd4;
        dec_ctrl.post_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // Lane routing; the swap exchanges x1 and y1 so DET2 computes x0*y1 - y0*x1.
  always_comb begin
    dec_entry.ctrl = dec_ctrl;
    dec_entry.x0   = a1;
    dec_entry.y0   = b1;
    dec_entry.x1   = swap ? b2 : a2;
    dec_entry.y1   = swap ? a2 : b2;
  end

  // ---------------------------------------------------------------------------
  // Handshake and occupancy FSM
  // ---------------------------------------------------------------------------
  assign drop_noop = (DROP_NOOP != 0) && (opcode == OP_NOOP);
  assign accept    = rx_valid_in & rx_ready_q;
  // A dropped NOOP completes its handshake but never occupies an entry.
  assign load      = accept & ~drop_noop;
  assign issue     = cmd_valid_out & cmd_ready_in;

  always_comb begin
    state_n      = state_q;
    main_ld_new  = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (load) begin
          state_n     = S_ONE;
          main_ld_new = 1'b1;
        end
      end
      S_ONE: begin
        case ({issue, load})
          2'b11: main_ld_new = 1'b1;
          2'b01: begin
            state_n = S_FULL;
            skid_ld = 1'b1;
          end
          2'b10: state_n = S_EMPTY;
          default: ;
        endcase
      end
      S_FULL: begin
        // rx_ready_out is low here, so no new instruction can arrive.
        if (issue) begin
          state_n      = S_ONE;
          main_ld_skid = 1'b1;
        end
      end
      default: state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      rx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      // Registered copy of "skid entry free" for the next cycle.
      rx_ready_q <= (state_n != S_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q    <= '0;
      skid_q    <= '0;
      issue_cnt <= '0;
    end else begin
      if (main_ld_new) begin
        main_q <= dec_entry;
      end else if (main_ld_skid) begin
        main_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= dec_entry;
      end
      if (issue) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

  assign rx_ready_out  = rx_ready_q;
  assign cmd_valid_out = (state_q != S_EMPTY);
  assign ctrl          = main_q.ctrl;
  assign x0            = main_q.x0;
  assign x1            = main_q.x1;
  assign y0            = main_q.y0;
  assign y1            = main_q.y1;

endmodule

// File: tb/tb_decode_stage_skid.sv
// Testbench for decode_stage_skid. Two instances share one stimulus stream:
//   u_a: OPW=5 (swap flag), DROP_NOOP=1, CNT_W=2
//   u_b: OPW=4, DROP_NOOP=0, CNT_W=8
// Each instance is checked against a queue model: commands accepted but not yet
// issued, ready while fewer than two are held, head of the queue on the outputs.
module tb_decode_stage_skid;
  import alu_pkg::*;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         rx_valid;
  logic         cmd_ready;
  logic [4:0]   op;
  logic [W-1:0] a1, a2, b1, b2;

  logic         a_rdy, a_vld, b_rdy, b_vld;
  alu_ctrl_t    a_ctrl, b_ctrl;
  logic [W-1:0] a_x0, a_x1, a_y0, a_y1;
  logic [W-1:0] b_x0, b_x1, b_y0, b_y1;
  logic [1:0]   a_cnt;
  logic [7:0]   b_cnt;

  decode_stage_skid #(.WIDTH(W), .OPW(5), .DROP_NOOP(1), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .rx_valid_in(rx_valid), .rx_ready_out(a_rdy), .op(op),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2), .cmd_valid_out(a_vld), .cmd_ready_in(cmd_ready),
    .ctrl(a_ctrl), .x0(a_x0), .x1(a_x1), .y0(a_y0), .y1(a_y1), .issue_cnt(a_cnt)
  );

  decode_stage_skid #(.WIDTH(W), .OPW(4), .DROP_NOOP(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .rx_valid_in(rx_valid), .rx_ready_out(b_rdy), .op(op[3:0]),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2), .cmd_valid_out(b_vld), .cmd_ready_in(cmd_ready),
    .ctrl(b_ctrl), .x0(b_x0), .x1(b_x1), .y0(b_y0), .y1(b_y1), .issue_cnt(b_cnt)
  );

  typedef struct packed {
    alu_ctrl_t    c;
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
  } cmd_t;

  cmd_t        qa[$];
  cmd_t        qb[$];
  int unsigned cnta, cntb;
  int unsigned tests, fails;

  // Control word from named fields, in table order:
  // pre_x_en pre_x_sub pre_y_en pre_y_sub mul_x_en mul_x_sel mul_y_en mul_y_sel post_en post_sub
  function automatic alu_ctrl_t mk(input int pxe, input int pxs, input int pye, input int pys,
                                   input int mxe, input int mxs, input int mye, input int mys,
                                   input int pe, input int ps);
    alu_ctrl_t c;
    c.pre_x_en  = (pxe != 0);
    c.pre_x_sub = (pxs != 0);
    c.pre_y_en  = (pye != 0);
    c.pre_y_sub = (pys != 0);
    c.mul_x_en  = (mxe != 0);
    c.mul_x_sel = 3'(mxs);
    c.mul_y_en  = (mye != 0);
    c.mul_y_sel = 3'(mys);
    c.post_en   = (pe != 0);
    c.post_sub  = (ps != 0);
    return c;
  endfunction

  function automatic alu_ctrl_t ref_ctrl(input logic [3:0] o);
    case (o)
      4'h0:                      return mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: return mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 0);
      4'h6:                      return mk(1, 0, 1, 0, 1, 4, 1, 4, 0, 0);
      4'h7:                      return mk(1, 1, 1, 1, 1, 4, 1, 4, 0, 0);
      4'h8, 4'h9, 4'hA:          return mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 1);
      4'hB:                      return mk(1, 1, 1, 1, 1, 2, 1, 2, 1, 1);
      4'hC:                      return mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 0);
      4'hD:                      return mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
      4'hE:                      return mk(0, 0, 1, 1, 1, 4, 1, 3, 1, 0);
      default:                   return mk(1, 1, 0, 0, 1, 3, 1, 4, 1, 0);
    endcase
  endfunction

  function automatic cmd_t exp_cmd(input logic [4:0] o, input int swap_ok);
    cmd_t c;
    c.c  = ref_ctrl(o[3:0]);
    c.x0 = a1;
    c.y0 = b1;
    if (swap_ok != 0 && o[4]) begin
      c.x1 = b2;
      c.y1 = a2;
    end else begin
      c.x1 = a2;
      c.y1 = b2;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic compare_all();
    check("a_ready", 32'(a_rdy), 32'(qa.size() < 2));
    check("a_valid", 32'(a_vld), 32'(qa.size() > 0));
    if (qa.size() > 0) begin
      check("a_ctrl", 32'(a_ctrl), 32'(qa[0].c));
      check("a_lanes", 32'({a_x0, a_x1, a_y0, a_y1}), 32'({qa[0].x0, qa[0].x1, qa[0].y0, qa[0].y1}));
    end
    check("a_cnt", 32'(a_cnt), cnta);
    check("b_ready", 32'(b_rdy), 32'(qb.size() < 2));
    check("b_valid", 32'(b_vld), 32'(qb.size() > 0));
    if (qb.size() > 0) begin
      check("b_ctrl", 32'(b_ctrl), 32'(qb[0].c));
      check("b_lanes", 32'({b_x0, b_x1, b_y0, b_y1}), 32'({qb[0].x0, qb[0].x1, qb[0].y0, qb[0].y1}));
    end
    check("b_cnt", 32'(b_cnt), cntb);
  endtask

  // One clock: model decisions from pre-edge state, then compare #1 after the edge.
  task automatic step();
    logic acc_a, acc_b, iss_a, iss_b, is_noop;
    cmd_t na, nb, tmp;
    acc_a   = rx_valid && (qa.size() < 2);
    acc_b   = rx_valid && (qb.size() < 2);
    iss_a   = cmd_ready && (qa.size() > 0);
    iss_b   = cmd_ready && (qb.size() > 0);
    is_noop = (op[3:0] == 4'h0);
    na      = exp_cmd(op, 1);
    nb      = exp_cmd(op, 0);
    @(posedge clk);
    #1;
    if (iss_a) begin
      tmp  = qa.pop_front();
      cnta = (cnta + 1) % 4;
    end
    if (acc_a && !is_noop) qa.push_back(na);
    if (iss_b) begin
      tmp  = qb.pop_front();
      cntb = (cntb + 1) % 256;
    end
    if (acc_b) qb.push_back(nb);
    compare_all();
  endtask

  task automatic drive(input int v, input int o, input int p, input int q, input int r,
                       input int s, input int rdy);
    rx_valid  = (v != 0);
    op        = 5'(o);
    a1        = 4'(p);
    a2        = 4'(q);
    b1        = 4'(r);
    b2        = 4'(s);
    cmd_ready = (rdy != 0);
  endtask

  task automatic check_reset();
    check("a_rst_valid", 32'(a_vld), 32'd0);
    check("a_rst_ready", 32'(a_rdy), 32'd1);
    check("a_rst_ctrl", 32'(a_ctrl), 32'd0);
    check("a_rst_lanes", 32'({a_x0, a_x1, a_y0, a_y1}), 32'd0);
    check("a_rst_cnt", 32'(a_cnt), 32'd0);
    check("b_rst_valid", 32'(b_vld), 32'd0);
    check("b_rst_ready", 32'(b_rdy), 32'd1);
    check("b_rst_cnt", 32'(b_cnt), 32'd0);
  endtask

  // Asserts reset with random inputs present (they must be ignored).
  task automatic do_reset();
    rst = 1'b1;
    drive(1, int'($urandom_range(0, 31)), int'($urandom), int'($urandom), int'($urandom),
          int'($urandom), 1);
    #1;
    qa.delete();
    qb.delete();
    cnta = 0;
    cntb = 0;
    check_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cnta  = 0;
    cntb  = 0;
    rst   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset();

    // T1: single DOT2 into an empty stage with the ALU ready.
    drive(1, 5'h01, 3, 2, 4, 5, 1);
    step();
    check("t1_valid", 32'(a_vld), 32'd1);
    check("t1_lanes", 32'({a_x0, a_x1, a_y0, a_y1}), 32'h3245);
    check("t1_ctrl", 32'(a_ctrl), 32'(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 0)));
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    check("t1_cnt", 32'(a_cnt), 32'd1);

    // T2: back-pressure fills both entries, then drains in order.
    drive(1, 5'h02, 1, 1, 1, 1, 0);
    step();
    drive(1, 5'h03, 2, 2, 2, 2, 0);
    step();
    check("t2_ready_low", 32'(a_rdy), 32'd0);
    drive(1, 5'h04, 3, 3, 3, 3, 0);
    step();
    step();
    check("t2_hold_lanes", 32'({a_x0, a_x1, a_y0, a_y1}), 32'h1111);
    check("t2_hold_ready", 32'(a_rdy), 32'd0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic acc;
      acc = rx_valid && (qa.size() < 2);
      step();
      if (i == 0) check("t2_first_drain", 32'(a_x0), 32'h2);
      if (acc) rx_valid = 1'b0;
    end
    check("t2_cnt", 32'(b_cnt), 32'd4);

    // T3: DET2 with the swap flag.
    do_reset();
    drive(1, 5'h19, 1, 2, 3, 4, 1);
    step();
    check("t3_x1", 32'(a_x1), 32'h4);
    check("t3_y1", 32'(a_y1), 32'h2);
    check("t3_post_sub", 32'(a_ctrl.post_sub), 32'd1);
    check("t3_noswap_x1", 32'(b_x1), 32'h2);
    drive(0, 0, 0, 0, 0, 0, 1);
    step();

    // T4: NOOP, VSUB2, NOOP stream.
    do_reset();
    drive(1, 5'h00, 1, 1, 1, 1, 1);
    step();
    check("t4_noop_dropped", 32'(a_vld), 32'd0);
    drive(1, 5'h07, 5, 6, 7, 8, 1);
    step();
    check("t4_vsub_sel", 32'(a_ctrl.mul_x_sel), 32'd4);
    check("t4_vsub_sub", 32'({a_ctrl.pre_x_sub, a_ctrl.pre_y_sub}), 32'd3);
    drive(1, 5'h00, 2, 2, 2, 2, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    check("t4_cnt_drop", 32'(a_cnt), 32'd1);
    check("t4_cnt_fwd", 32'(b_cnt), 32'd3);

    // T5: five back-to-back commands, counter wraps at 4.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive((k <= 5) ? 1 : 0, k, k, k, k, k, 1);
      step();
      if (k <= 5) check("t5_sustain", 32'(a_vld), 32'd1);
      if (k >= 2) check("t5_cnt", 32'(a_cnt), 32'((k - 1) % 4));
    end

    // T6: reset while FULL and stalled.
    do_reset();
    drive(1, 5'h01, 9, 9, 9, 9, 0);
    step();
    drive(1, 5'h02, 10, 10, 10, 10, 0);
    step();
    check("t6_full", 32'(a_rdy), 32'd0);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) step();
    check("t6_no_stale", 32'(a_vld), 32'd0);
    check("t6_ready", 32'(a_rdy), 32'd1);
    check("t6_cnt", 32'(a_cnt), 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 31)),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            ($urandom_range(0, 2) != 0) ? 1 : 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
